// File: rtl/timer_ctrl.sv
// Interval-timer controller: start/stop/pause sequencing of a BW-bit up-counter
// through a PW-bit prescaler. Optional sticky irq_o flag via TIMER_CTRL_IRQ_EN.
module timer_ctrl #(
  parameter int BW = 8,
  parameter int PW = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          pause_i,
  input  logic          mode_i,
  input  logic [BW-1:0] period_i,
  input  logic [PW-1:0] presc_i,
  output logic [BW-1:0] count_o,
  output logic          busy_o,
  output logic          tick_o,
`ifdef TIMER_CTRL_IRQ_EN
  output logic          done_o,
  input  logic          irq_clr_i,
  output logic          irq_o
`else
  output logic          done_o
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic          mode_r;
  logic [BW-1:0] period_r;
  logic [PW-1:0] presc_r;
  logic [PW-1:0] pre_cnt;
  logic          en;
  logic          term;

  assign en   = (state == RUN) && (pre_cnt == presc_r) && !pause_i;
  assign term = en && (count_o == period_r);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      mode_r   <= 1'b0;
      period_r <= '0;
      presc_r  <= '0;
      pre_cnt  <= '0;
      count_o  <= '0;
      busy_o   <= 1'b0;
      tick_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      tick_o <= 1'b0;
      done_o <= 1'b0;
      if (stop_i) begin
        state   <= IDLE;
        busy_o  <= 1'b0;
        count_o <= '0;
        pre_cnt <= '0;
      end else if (start_i) begin
        // Restart discards any terminal count landing on this edge.
        state    <= RUN;
        busy_o   <= 1'b1;
        mode_r   <= mode_i;
        period_r <= period_i;
        presc_r  <= presc_i;
        count_o  <= '0;
        pre_cnt  <= '0;
      end else if (state == RUN && !pause_i) begin
        if (en) begin
          pre_cnt <= '0;
          if (term) begin
            tick_o <= 1'b1;
            if (mode_r) begin
              count_o <= '0;
            end else begin
              done_o <= 1'b1;
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            count_o <= count_o + 1'b1;
          end
        end else begin
          pre_cnt <= pre_cnt + 1'b1;
        end
      end
    end
  end

`ifdef TIMER_CTRL_IRQ_EN
  logic irq_set;

  // Set when a pulse is being launched or is currently visible; set beats clear.
  assign irq_set = (term && !stop_i && !start_i) || tick_o || done_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) irq_o <= 1'b0;
    else if (irq_set) irq_o <= 1'b1;
    else if (irq_clr_i) irq_o <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed, table-driven bench for timer_ctrl (BW=8, PW=4).
module tb_timer_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       start_i = 1'b0, stop_i = 1'b0, pause_i = 1'b0, mode_i = 1'b0;
  logic [7:0] period_i = '0;
  logic [3:0] presc_i = '0;
  logic [7:0] count_o;
  logic       busy_o, tick_o, done_o;
  logic       irq_clr_i = 1'b0;
  logic       irq_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  timer_ctrl #(.BW(8), .PW(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .start_i(start_i), .stop_i(stop_i), .pause_i(pause_i), .mode_i(mode_i),
    .period_i(period_i), .presc_i(presc_i),
    .count_o(count_o), .busy_o(busy_o), .tick_o(tick_o),
`ifdef TIMER_CTRL_IRQ_EN
    .done_o(done_o), .irq_clr_i(irq_clr_i), .irq_o(irq_o)
`else
    .done_o(done_o)
`endif
  );

`ifndef TIMER_CTRL_IRQ_EN
  assign irq_o = 1'b0;
`endif

  typedef struct {
    logic       start, stop, pause, mode;
    logic [7:0] period;
    logic [3:0] presc;
    logic [7:0] e_count;
    logic       e_busy, e_tick, e_done;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic st, sp, pa, md, input logic [7:0] per, input logic [3:0] pr,
                     input logic [7:0] ec, input logic eb, et, ed);
    vec_t v;
    v.start = st; v.stop = sp; v.pause = pa; v.mode = md;
    v.period = per; v.presc = pr;
    v.e_count = ec; v.e_busy = eb; v.e_tick = et; v.e_done = ed;
    vq.push_back(v);
  endtask

  // Idle-input cycle with expected outputs
  task automatic nop(input logic [7:0] ec, input logic eb, et, ed);
    add(0, 0, 0, 0, 8'd0, 4'd0, ec, eb, et, ed);
  endtask

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got count=%0d busy=%0b tick=%0b done=%0b, want count=%0d busy=%0b tick=%0b done=%0b",
               name, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b, want %0b", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, sp, pa, md, input logic [7:0] per, input logic [3:0] pr);
    start_i = st; stop_i = sp; pause_i = pa; mode_i = md; period_i = per; presc_i = pr;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    check("reset_state", {count_o, busy_o, tick_o, done_o}, 11'd0);
    #10 rst_n_i = 1'b1;
    step();

    // Asynchronous reset mid-run at count 5
    drive(1, 0, 0, 1, 8'd9, 4'd0); step();
    drive(0, 0, 0, 0, 8'd0, 4'd0);
    for (int i = 0; i < 5; i++) step();
    check("pre_async_reset", {count_o, busy_o, tick_o, done_o}, {8'd5, 3'b100});
    #2 rst_n_i = 1'b0;
    #1 check("async_reset", {count_o, busy_o, tick_o, done_o}, 11'd0);
    #2 rst_n_i = 1'b1;
    step();

    // Periodic, period 3, presc 0: tick after E4, E8, E12
    add(1, 0, 0, 1, 8'd3, 4'd0, 8'd0, 1, 0, 0);
    for (int e = 1; e <= 12; e++) nop(8'(e % 4), 1, (e % 4) == 0, 0);
    add(0, 1, 0, 0, 8'd0, 4'd0, 8'd0, 0, 0, 0);
    // Pause in IDLE ignored
    add(0, 0, 1, 0, 8'd0, 4'd0, 8'd0, 0, 0, 0);
    // One-shot, period 2, presc 1: done after E6, count holds
    add(1, 0, 0, 0, 8'd2, 4'd1, 8'd0, 1, 0, 0);
    nop(0, 1, 0, 0); nop(1, 1, 0, 0); nop(1, 1, 0, 0); nop(2, 1, 0, 0); nop(2, 1, 0, 0);
    nop(2, 0, 1, 1); nop(2, 0, 0, 0); nop(2, 0, 0, 0);
    // Periodic, period 4: pause three cycles at count 2, tick after E8
    add(1, 0, 0, 1, 8'd4, 4'd0, 8'd0, 1, 0, 0);
    nop(1, 1, 0, 0); nop(2, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 8'd0, 4'd0, 8'd2, 1, 0, 0);
    nop(3, 1, 0, 0); nop(4, 1, 0, 0); nop(0, 1, 1, 0); nop(1, 1, 0, 0);
    // Pause on terminal cycle: no tick, then tick once released
    nop(2, 1, 0, 0); nop(3, 1, 0, 0); nop(4, 1, 0, 0);
    add(0, 0, 1, 0, 8'd0, 4'd0, 8'd4, 1, 0, 0);
    nop(0, 1, 1, 0);
    add(0, 1, 0, 0, 8'd0, 4'd0, 8'd0, 0, 0, 0);
    // One-shot, period 1: start+stop on terminal edge -> IDLE, no pulse
    add(1, 0, 0, 0, 8'd1, 4'd0, 8'd0, 1, 0, 0);
    nop(1, 1, 0, 0);
    add(1, 1, 0, 0, 8'd1, 4'd0, 8'd0, 0, 0, 0);
    nop(0, 0, 0, 0);
    // One-shot, period 1: start alone on terminal edge -> restart, no pulse
    add(1, 0, 0, 0, 8'd1, 4'd0, 8'd0, 1, 0, 0);
    nop(1, 1, 0, 0);
    add(1, 0, 0, 0, 8'd1, 4'd0, 8'd0, 1, 0, 0);
    nop(1, 1, 0, 0); nop(1, 0, 1, 1); nop(1, 0, 0, 0);
    // Periodic, period 0, presc 0: tick continuously; stop suppresses it
    add(1, 0, 0, 1, 8'd0, 4'd0, 8'd0, 1, 0, 0);
    nop(0, 1, 1, 0); nop(0, 1, 1, 0); nop(0, 1, 1, 0);
    add(0, 1, 0, 0, 8'd0, 4'd0, 8'd0, 0, 0, 0);
    // One-shot, period 0, presc 2: done after 3 cycles
    add(1, 0, 0, 0, 8'd0, 4'd2, 8'd0, 1, 0, 0);
    nop(0, 1, 0, 0); nop(0, 1, 0, 0); nop(0, 0, 1, 1); nop(0, 0, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].start, vq[i].stop, vq[i].pause, vq[i].mode, vq[i].period, vq[i].presc);
      step();
      check($sformatf("vec%0d", i), {count_o, busy_o, tick_o, done_o},
            {vq[i].e_count, vq[i].e_busy, vq[i].e_tick, vq[i].e_done});
    end
    drive(0, 0, 0, 0, 8'd0, 4'd0);
    step();

`ifdef TIMER_CTRL_IRQ_EN
    // Periodic, period 1, presc 1: ticks after E4, E8, E12
    check1("irq_idle", irq_o, 1'b0);
    drive(1, 0, 0, 1, 8'd1, 4'd1); step();
    drive(0, 0, 0, 0, 8'd0, 4'd0);
    for (int e = 1; e <= 3; e++) step();
    check1("irq_before_tick", irq_o, 1'b0);
    step();
    check1("irq_with_tick", irq_o, 1'b1);
    check1("irq_tick_seen", tick_o, 1'b1);
    for (int e = 5; e <= 7; e++) step();
    check1("irq_sticky", irq_o, 1'b1);
    irq_clr_i = 1'b1; step(); irq_clr_i = 1'b0;
    check1("irq_clr_on_tick_tick", tick_o, 1'b1);
    check1("irq_clr_on_tick", irq_o, 1'b1);
    step();
    irq_clr_i = 1'b1; step(); irq_clr_i = 1'b0;
    check1("irq_clr_quiet", irq_o, 1'b0);
    drive(0, 1, 0, 0, 8'd0, 4'd0); step(); drive(0, 0, 0, 0, 8'd0, 4'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
